// File: rtl/fetch_sequencer.sv
// Fetch controller for the 8-bit lab core: it scans the ROM for label markers, then streams instructions to decode.
// Optional feature: define FETCH_BRANCH_COUNT_EN to add branch_cnt_o, a saturating count of accepted branches.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] SCAN_LAST = ADDR_W'(8'hFE),
    parameter int unsigned       NLABEL    = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_inst_i,
    output logic [7:0]        inst_o,
    output logic              inst_valid_o,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [3:0]        branch_label_i,
    output logic              ready_o,
    output logic              halted_o,
    output logic              fault_o
`ifdef FETCH_BRANCH_COUNT_EN
    ,
    output logic [15:0]       branch_cnt_o
`endif
);

    typedef enum logic [2:0] {S_SCAN, S_DONE, S_IDLE, S_FETCH, S_HALT} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] tbl_q [16];
    logic [15:0]       lbl_vld_q;
    logic [7:0]        inst_q;
    logic              valid_q, ready_q, halted_q, fault_q;

    logic [ADDR_W-1:0] pc_inc_d, br_tgt_d;
    logic [3:0]        rom_lbl;
    logic              is_marker, scan_hit, scan_end, lbl_ok, start_ok;

    always_comb begin
        pc_inc_d  = pc_q + ADDR_W'(1);
        br_tgt_d  = tbl_q[branch_label_i] + ADDR_W'(1);
        rom_lbl   = rom_inst_i[3:0];
        is_marker = (rom_inst_i[7:4] == 4'hF) && (rom_lbl != 4'hF);
        scan_hit  = is_marker && (32'(rom_lbl) < NLABEL) && !lbl_vld_q[rom_lbl];
        scan_end  = (rom_inst_i == 8'hFF) || (pc_q == SCAN_LAST);
        lbl_ok    = (32'(branch_label_i) < NLABEL) && lbl_vld_q[branch_label_i];
        start_ok  = start_i && (state_q inside {S_IDLE, S_FETCH, S_HALT});
    end

    // pc_q doubles as the scan counter; S_DONE adds the cycle before ready_o rises.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_SCAN;
            pc_q      <= '0;
            lbl_vld_q <= '0;
            inst_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) tbl_q[i] <= '0;
        end else begin
            case (state_q)
                S_SCAN: begin
                    if (scan_hit) begin
                        tbl_q[rom_lbl]     <= pc_q;
                        lbl_vld_q[rom_lbl] <= 1'b1;
                    end
                    if (scan_end) state_q <= S_DONE;
                    else          pc_q    <= pc_inc_d;
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    pc_q    <= '0;
                    state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (start_ok) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        fault_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (start_ok) begin
                        pc_q    <= '0;
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                    end else if (branch_i) begin
                        valid_q <= 1'b0;
                        if (lbl_ok) begin
                            pc_q <= br_tgt_d;
                        end else begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                    end else if (!stall_i) begin
                        if (rom_inst_i == 8'hFF) begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            valid_q  <= 1'b0;
                            state_q  <= S_HALT;
                        end else if (is_marker) begin
                            valid_q <= 1'b0;
                            pc_q    <= pc_inc_d;
                        end else begin
                            inst_q  <= rom_inst_i;
                            valid_q <= 1'b1;
                            // Halt is presented first; pc stays on it and halted_o follows next cycle.
                            if (rom_inst_i == 8'hE0) state_q <= S_HALT;
                            else                     pc_q    <= pc_inc_d;
                        end
                    end
                end
                S_HALT: begin
                    valid_q <= 1'b0;
                    if (start_ok) begin
                        state_q  <= S_FETCH;
                        pc_q     <= '0;
                        fault_q  <= 1'b0;
                        halted_q <= 1'b0;
                    end else begin
                        halted_q <= 1'b1;
                    end
                end
                default: state_q <= S_SCAN;
            endcase
        end
    end

`ifdef FETCH_BRANCH_COUNT_EN
    logic [15:0] bcnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            bcnt_q <= '0;
        else if (start_ok)
            bcnt_q <= '0;
        else if ((state_q == S_FETCH) && branch_i && lbl_ok && (bcnt_q != '1))
            bcnt_q <= bcnt_q + 16'd1;
    end

    assign branch_cnt_o = bcnt_q;
`endif

    assign rom_addr_o   = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign ready_o      = ready_q;
    assign halted_o     = halted_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random programs checked against a behavioural model.
// Define FETCH_BRANCH_COUNT_EN to also check branch_cnt_o.
module tb_fetch_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b1;
    logic       start_i = 1'b0, stall_i = 1'b0, branch_i = 1'b0;
    logic [3:0] branch_label_i = '0;
    logic [7:0] rom_addr_o, rom_inst_i, inst_o;
    logic       inst_valid_o, ready_o, halted_o, fault_o;
`ifdef FETCH_BRANCH_COUNT_EN
    logic [15:0] branch_cnt_o;
`endif

    logic [7:0] rom [256];
    always_comb rom_inst_i = rom[rom_addr_o];

    always #5 clk_i = ~clk_i;

    fetch_sequencer #(.ADDR_W(8), .SCAN_LAST(8'hFE), .NLABEL(15)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
        .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
        .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .stall_i(stall_i), .branch_i(branch_i), .branch_label_i(branch_label_i),
        .ready_o(ready_o), .halted_o(halted_o), .fault_o(fault_o)
`ifdef FETCH_BRANCH_COUNT_EN
        , .branch_cnt_o(branch_cnt_o)
`endif
    );

    int vectors = 0;
    int errors  = 0;

    // Behavioural model: program state in terms of "running / halt pending / halted".
    logic [7:0] m_pc, m_inst;
    logic       m_valid, m_halted, m_fault, m_run, m_pend, m_scan;
    int         m_cnt;
    logic [7:0] m_tab [16];
    bit         m_have [16];

    task automatic model_reset();
        m_pc = 0; m_inst = 0; m_valid = 0; m_halted = 0; m_fault = 0;
        m_run = 0; m_pend = 0; m_scan = 1; m_cnt = 0;
    endtask

    // Label table from the ROM; returns the address at which the scan stops.
    function automatic int model_scan();
        int last = 254;
        for (int a = 0; a < 255; a++) if (rom[a] == 8'hFF) begin last = a; break; end
        for (int i = 0; i < 16; i++) m_have[i] = 0;
        for (int a = 0; a <= last; a++) begin
            logic [7:0] w = rom[a];
            if (w[7:4] == 4'hF && w[3:0] != 4'hF && !m_have[w[3:0]]) begin
                m_have[w[3:0]] = 1; m_tab[w[3:0]] = 8'(a);
            end
        end
        return last;
    endfunction

    task automatic tick(input logic st, input logic sb, input logic br, input logic [3:0] lb);
        logic [7:0] w;
        start_i = st; stall_i = sb; branch_i = br; branch_label_i = lb;
        if (!m_scan) begin
            if (st) begin
                m_pc = 0; m_fault = 0; m_valid = 0; m_run = 1; m_halted = 0; m_pend = 0; m_cnt = 0;
            end else if (m_pend) begin
                m_pend = 0; m_run = 0; m_halted = 1; m_valid = 0;
            end else if (m_run) begin
                if (br) begin
                    m_valid = 0;
                    if (lb != 4'hF && m_have[lb]) begin
                        m_pc = m_tab[lb] + 8'd1;
                        if (m_cnt < 65535) m_cnt++;
                    end else begin
                        m_fault = 1; m_halted = 1; m_run = 0;
                    end
                end else if (!sb) begin
                    w = rom[m_pc];
                    if (w == 8'hFF) begin
                        m_fault = 1; m_halted = 1; m_run = 0; m_valid = 0;
                    end else if (w[7:4] == 4'hF) begin
                        m_valid = 0; m_pc++;
                    end else begin
                        m_inst = w; m_valid = 1;
                        if (w == 8'hE0) m_pend = 1; else m_pc++;
                    end
                end
            end
        end
        @(posedge clk_i); #1;
        start_i = 0; stall_i = 0; branch_i = 0;
    endtask

    task automatic release_reset();
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
    endtask

    task automatic fill_rom(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    task automatic test_reset();
        int last;
        fill_rom(8'hFF); rom[0] = 8'hE0;
        #1 rst_n_i = 1'b0; model_reset();
        #2;
        vectors++; if (rom_addr_o !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", rom_addr_o); end
        vectors++; if (inst_o !== 8'h00) begin errors++; $display("FAIL reset_inst: got %h want 00", inst_o); end
        vectors++; if ({inst_valid_o, ready_o, halted_o, fault_o} !== 4'b0000)
            begin errors++; $display("FAIL reset_flags: got %b want 0000", {inst_valid_o, ready_o, halted_o, fault_o}); end
`ifdef FETCH_BRANCH_COUNT_EN
        vectors++; if (branch_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_bcnt: got %h want 0000", branch_cnt_o); end
`endif
        release_reset();
        last = model_scan();
        repeat (last + 1) tick(0, 0, 0, 0);
        vectors++; if (ready_o !== 1'b0) begin errors++; $display("FAIL scan_early_ready: got %b want 0", ready_o); end
        tick(0, 0, 0, 0); m_scan = 0;
        vectors++; if (ready_o !== 1'b1) begin errors++; $display("FAIL scan_ready_cycle3: got %b want 1", ready_o); end
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        vectors++; if ({inst_valid_o, inst_o, halted_o} !== {1'b1, 8'hE0, 1'b0})
            begin errors++; $display("FAIL halt_present: got v=%b i=%h h=%b want v=1 i=e0 h=0", inst_valid_o, inst_o, halted_o); end
        tick(0, 0, 0, 0);
        vectors++; if ({inst_valid_o, halted_o} !== 2'b01)
            begin errors++; $display("FAIL halt_state: got v=%b h=%b want v=0 h=1", inst_valid_o, halted_o); end
    endtask

    task automatic load_stream_rom();
        int last;
        fill_rom(8'hFF);
        rom[0] = 8'h11; rom[1] = 8'hF2; rom[2] = 8'h19; rom[3] = 8'hE0;
        rst_n_i = 1'b0; model_reset();
        release_reset();
        last = model_scan();
        repeat (last + 2) tick(0, 0, 0, 0);
        m_scan = 0;
    endtask

    task automatic test_stream();
        logic [8:0] exp_seq [4] = '{{1'b1, 8'h11}, {1'b0, 8'h11}, {1'b1, 8'h19}, {1'b1, 8'hE0}};
        load_stream_rom();
        vectors++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b want 1", ready_o); end
        tick(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            vectors++; if ({inst_valid_o, inst_o} !== exp_seq[i])
                begin errors++; $display("FAIL stream_%0d: got v=%b i=%h want %h", i, inst_valid_o, inst_o, exp_seq[i]); end
        end
        tick(0, 0, 0, 0);
        vectors++; if ({halted_o, rom_addr_o} !== {1'b1, 8'h03})
            begin errors++; $display("FAIL stream_halt: got h=%b a=%h want h=1 a=03", halted_o, rom_addr_o); end
    endtask

    task automatic test_branch();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 4'd2);
        vectors++; if ({rom_addr_o, inst_valid_o} !== {8'h02, 1'b0})
            begin errors++; $display("FAIL branch_target: got a=%h v=%b want a=02 v=0", rom_addr_o, inst_valid_o); end
        tick(0, 0, 0, 0);
        vectors++; if ({inst_valid_o, inst_o} !== {1'b1, 8'h19})
            begin errors++; $display("FAIL branch_after: got v=%b i=%h want v=1 i=19", inst_valid_o, inst_o); end
        tick(0, 0, 1, 4'd5);
        vectors++; if ({fault_o, halted_o, rom_addr_o} !== {1'b1, 1'b1, 8'h03})
            begin errors++; $display("FAIL bad_label: got f=%b h=%b a=%h want f=1 h=1 a=03", fault_o, halted_o, rom_addr_o); end
        tick(1, 0, 0, 0);
        vectors++; if ({fault_o, halted_o} !== 2'b00)
            begin errors++; $display("FAIL start_clears_fault: got f=%b h=%b want 00", fault_o, halted_o); end
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 4'hF);
        vectors++; if ({fault_o, halted_o, rom_addr_o} !== {1'b1, 1'b1, 8'h01})
            begin errors++; $display("FAIL label15: got f=%b h=%b a=%h want f=1 h=1 a=01", fault_o, halted_o, rom_addr_o); end
    endtask

    task automatic test_stall();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0);
            vectors++; if ({inst_valid_o, inst_o, rom_addr_o} !== {1'b1, 8'h11, 8'h01})
                begin errors++; $display("FAIL stall_%0d: got v=%b i=%h a=%h want v=1 i=11 a=01", i, inst_valid_o, inst_o, rom_addr_o); end
        end
        tick(0, 1, 1, 4'd2);
        vectors++; if ({rom_addr_o, inst_valid_o} !== {8'h02, 1'b0})
            begin errors++; $display("FAIL branch_beats_stall: got a=%h v=%b want a=02 v=0", rom_addr_o, inst_valid_o); end
`ifdef FETCH_BRANCH_COUNT_EN
        vectors++; if (branch_cnt_o !== 16'd1) begin errors++; $display("FAIL bcnt_one: got %0d want 1", branch_cnt_o); end
`endif
    endtask

    task automatic test_mid_scan_reset();
        int last;
        fill_rom(8'h11);
        rom[8'h05] = 8'hF3; rom[8'h20] = 8'hF3; rom[8'h30] = 8'hFF;
        rst_n_i = 1'b0; model_reset();
        release_reset();
        for (int i = 0; i < 16; i++) tick(i[2], 0, 0, 0);
        vectors++; if ({rom_addr_o, ready_o} !== {8'h10, 1'b0})
            begin errors++; $display("FAIL midscan_addr: got a=%h r=%b want a=10 r=0", rom_addr_o, ready_o); end
        rst_n_i = 1'b0; model_reset();
        #2;
        vectors++; if ({rom_addr_o, ready_o} !== {8'h00, 1'b0})
            begin errors++; $display("FAIL midscan_reset: got a=%h r=%b want a=00 r=0", rom_addr_o, ready_o); end
        release_reset();
        last = model_scan();
        repeat (last + 1) tick(1, 0, 0, 0);
        vectors++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rescan_early: got %b want 0", ready_o); end
        tick(0, 0, 0, 0); m_scan = 0;
        vectors++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rescan_ready: got %b want 1", ready_o); end
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 4'd3);
        vectors++; if (rom_addr_o !== 8'h06)
            begin errors++; $display("FAIL first_label_wins: got %h want 06", rom_addr_o); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 12; p++) begin
            int last, len, r;
            fill_rom(8'hFF);
            len = $urandom_range(40, 8);
            for (int a = 0; a < len; a++) begin
                r = $urandom_range(99);
                if      (r < 60) rom[a] = 8'($urandom_range(8'hDF));
                else if (r < 80) rom[a] = 8'hF0 | 8'($urandom_range(14));
                else if (r < 86) rom[a] = 8'hE0;
                else             rom[a] = 8'hE1 + 8'($urandom_range(14));
            end
            rst_n_i = 1'b0; model_reset();
            release_reset();
            last = model_scan();
            repeat (last + 1) tick(0, 0, 0, 0);
            vectors++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rnd_scan_early p%0d: got %b want 0", p, ready_o); end
            tick(0, 0, 0, 0); m_scan = 0;
            vectors++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rnd_scan_ready p%0d: got %b want 1", p, ready_o); end
            for (int c = 0; c < 100; c++) begin
                logic st, sb, br;
                st = (!m_run && !m_pend) ? ($urandom_range(1) == 1) : ($urandom_range(99) < 2);
                sb = $urandom_range(99) < 25;
                br = $urandom_range(99) < 10;
                tick(st, sb, br, 4'($urandom_range(15)));
                vectors++; if (rom_addr_o !== m_pc)
                    begin errors++; $display("FAIL rnd_addr p%0d c%0d: got %h want %h", p, c, rom_addr_o, m_pc); end
                vectors++; if ({inst_valid_o, inst_o} !== {m_valid, m_inst})
                    begin errors++; $display("FAIL rnd_inst p%0d c%0d: got v=%b i=%h want v=%b i=%h", p, c, inst_valid_o, inst_o, m_valid, m_inst); end
                vectors++; if ({halted_o, fault_o, ready_o} !== {m_halted, m_fault, 1'b1})
                    begin errors++; $display("FAIL rnd_flags p%0d c%0d: got h=%b f=%b r=%b want h=%b f=%b r=1", p, c, halted_o, fault_o, ready_o, m_halted, m_fault); end
`ifdef FETCH_BRANCH_COUNT_EN
                vectors++; if (branch_cnt_o !== 16'(m_cnt))
                    begin errors++; $display("FAIL rnd_bcnt p%0d c%0d: got %0d want %0d", p, c, branch_cnt_o, m_cnt); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_branch();
        test_stall();
        test_mid_scan_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
